// File: rtl/framebuf_ctrl.sv
`timescale 1ns/1ps
// framebuf_ctrl: sequences a 128x128 RGB frame buffer through one load/drain
// cycle per start pulse. Upstream and downstream use valid/ready; the buffer
// uses four-phase req/ack on both its receive and send sides. Any buffer
// handshake edge that stalls for TIMEOUT cycles parks the controller in ERR.
module framebuf_ctrl #(
  parameter int PIXELS  = 16384,
  parameter int CNT_W   = 14,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_pixel,
  input  logic             buf_recev_req,
  output logic             buf_recev_ack,
  output logic [23:0]      buf_pixel_in,
  output logic             buf_send_req,
  input  logic             buf_send_ack,
  input  logic [23:0]      buf_pixel_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pix_count,
  output logic [7:0]       frame_count,
  output logic [3:0]       state_out
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(PIXELS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LD_WAIT = 4'd1,
    LD_ACK  = 4'd2,
    LD_REL  = 4'd3,
    DR_REQ  = 4'd4,
    DR_REL  = 4'd5,
    DR_HOLD = 4'd6,
    DONE    = 4'd7,
    ERR     = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pix_q, pix_d;
  logic [7:0]        frame_q, frame_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              ov_q, ov_d;
  logic [23:0]       bpi_q, bpi_d;
  logic [23:0]       op_q, op_d;
  logic              timed_out;

  // The final timed cycle of a stalled handshake edge is the one that trips ERR.
  assign timed_out = (wait_q == WAIT_LAST);

  // State, counters and the two pixel holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      frame_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      bpi_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      frame_q <= frame_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      bpi_q   <= bpi_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic for the load/drain sequence and the handshake watchdog.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    frame_d = frame_q;
    err_d   = err_q;
    ov_d    = ov_q;
    bpi_d   = bpi_q;
    op_d    = op_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LD_WAIT;
          pix_d   = '0;
          err_d   = 1'b0;
        end
      end
      LD_WAIT: begin
        if (buf_recev_req && in_valid) begin
          bpi_d   = in_pixel;
          state_d = LD_ACK;
        end
      end
      LD_ACK: begin
        if (!buf_recev_req)  state_d = LD_REL;
        else if (timed_out)  state_d = ERR;
      end
      LD_REL: begin
        if (pix_q == LAST_PIX) begin
          pix_d   = '0;
          state_d = DR_REQ;
        end else begin
          pix_d   = pix_q + CNT_W'(1);
          state_d = LD_WAIT;
        end
      end
      DR_REQ: begin
        if (buf_send_ack)    state_d = DR_REL;
        else if (timed_out)  state_d = ERR;
      end
      DR_REL: begin
        // Buffer data is valid once it has dropped its ack.
        if (!buf_send_ack) begin
          op_d    = buf_pixel_out;
          ov_d    = 1'b1;
          state_d = DR_HOLD;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      DR_HOLD: begin
        if (out_ready) begin
          ov_d = 1'b0;
          if (pix_q == LAST_PIX) begin
            state_d = DONE;
          end else begin
            pix_d   = pix_q + CNT_W'(1);
            state_d = DR_REQ;
          end
        end
      end
      DONE: begin
        frame_d = frame_q + 8'd1;
        pix_d   = '0;
        state_d = IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    if (state_d == ERR) err_d = 1'b1;

    // Watchdog restarts on every state change and only runs on buffer edges.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == LD_ACK || state_q == DR_REQ || state_q == DR_REL) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign in_ready      = (state_q == LD_WAIT) && buf_recev_req && in_valid;
  assign buf_recev_ack = (state_q == LD_ACK);
  assign buf_send_req  = (state_q == DR_REQ);
  assign buf_pixel_in  = bpi_q;
  assign out_valid     = ov_q;
  assign out_pixel     = op_q;
  assign busy          = (state_q != IDLE) && (state_q != ERR);
  assign done          = (state_q == DONE);
  assign error         = err_q;
  assign pix_count     = pix_q;
  assign frame_count   = frame_q;
  assign state_out     = state_q;

endmodule

// File: doc/framebuf_ctrl.md
Name: framebuf_ctrl

Overview:
- Sequences the 128x128 RGB frame buffer through one full load/drain cycle per `start`.
- Load: accepts pixels from an upstream valid/ready stream and feeds them into the buffer's receive side using the buffer's four-phase req/ack handshake.
- Drain: pulls pixels out of the buffer's send side and presents them on a downstream valid/ready stream.
- Sits between the capture front-end and the image-processing pipeline. Tracks pixel/frame counts and flags handshake timeouts.

Parameters:
- PIXELS, 16384, pixels per frame (128*128).
- CNT_W, 14, pixel counter width (must hold PIXELS-1).
- TIMEOUT, 1023, maximum cycles spent waiting on any single buffer handshake edge before error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame cycle when idle
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  upstream pixel accepted (one-cycle pulse)
- in_pixel  in  24  upstream pixel {a,b,c}
- out_valid  out  1  downstream pixel valid
- out_ready  in  1  downstream accepts
- out_pixel  out  24  downstream pixel {a,b,c}
- buf_recev_req  in  1  buffer ready to receive
- buf_recev_ack  out  1  controller data-valid ack to buffer
- buf_pixel_in  out  24  pixel driven to buffer {a,b,c}
- buf_send_req  out  1  controller requests next pixel from buffer
- buf_send_ack  in  1  buffer acknowledges send request
- buf_pixel_out  in  24  buffer output pixel {a,b,c}
- busy  out  1  high in any state except IDLE/ERR
- done  out  1  one-cycle pulse at end of drain
- error  out  1  sticky timeout flag
- pix_count  out  CNT_W  pixels transferred in current phase
- frame_count  out  8  completed frames, wraps 255->0
- state_out  out  4  current state encoding

Behaviour:
- Reset (async, low): state IDLE. All outputs 0; buf_pixel_in=0, out_pixel=0, counters 0.
- States: IDLE=0, LD_WAIT=1, LD_ACK=2, LD_REL=3, DR_REQ=4, DR_REL=5, DR_HOLD=6, DONE=7, ERR=8.
- IDLE: start=1 -> LD_WAIT, pix_count<=0, error<=0. start is ignored in every other state.
- LD_WAIT: when buf_recev_req=1 and in_valid=1:
  - in_ready=1 for that cycle; buf_pixel_in<=in_pixel; -> LD_ACK.
  - If only one of the two is high, wait.
- LD_ACK: buf_recev_ack=1, held until buf_recev_req=0 -> LD_REL.
- LD_REL: buf_recev_ack=0 for exactly one cycle.
  - pix_count==PIXELS-1: pix_count<=0, -> DR_REQ.
  - Otherwise: pix_count+1, -> LD_WAIT.
- buf_pixel_in is held stable from LD_WAIT exit through LD_REL.
- DR_REQ: buf_send_req=1; when buf_send_ack=1 -> DR_REL.
- DR_REL: buf_send_req=0; when buf_send_ack=0:
  - out_pixel<=buf_pixel_out (buffer data is valid in this cycle); out_valid<=1; -> DR_HOLD.
- DR_HOLD: out_valid and out_pixel held until out_ready=1 (transfer on that edge).
  - out_valid<=0.
  - pix_count==PIXELS-1: -> DONE.
  - Otherwise: pix_count+1, -> DR_REQ.
  - Backpressure of any length is legal and is not counted by the timeout.
- DONE: done=1 for one cycle; frame_count+1 (mod 256); pix_count<=0; -> IDLE.
- Timeout:
  - A wait counter clears on every state change.
  - It increments only in LD_ACK, DR_REQ and DR_REL.
  - On reaching TIMEOUT: -> ERR. ERR drops buf_recev_ack and buf_send_req, sets error=1, holds pix_count.
  - ERR is exited only by reset; the buffer must be reset together with the controller.
- LD_WAIT is not timed; upstream starvation is legal.
- Latency per load pixel: minimum 4 cycles. Per drain pixel: minimum 4 cycles with out_ready held high.
- Reset mid-operation returns to IDLE with no partial done pulse. The buffer shares the same reset, so both restart at address 0.
- buf_recev_ack and buf_send_req are never high simultaneously. in_ready is never high outside LD_WAIT.

Test Plan:
- Full frame, in_valid and out_ready tied high, buffer model echoing address as pixel → 16384 loads then 16384 outputs with out_pixel = load order. done pulses once; frame_count=1; total cycles approx. 8*16384.
- Upstream gaps (in_valid 50% random) and downstream backpressure (out_ready low for 20 cycles mid-drain) → no lost or duplicated pixels; out_pixel stable while out_valid=1 and out_ready=0; no error.
- Buffer model never raises buf_send_ack in DR_REQ → error=1 and state ERR after exactly TIMEOUT cycles; buf_send_req=0; busy=0.
- Assert reset at pixel 5000 of the load, then start again → all outputs return to 0; new frame completes; frame_count=1.
- start pulsed during busy, and 256 back-to-back frames run → extra start ignored; frame_count wraps to 0 after 256 frames.
- Handshake checker: buf_recev_ack rises only while buf_recev_req=1 and falls only after buf_recev_req=0; buf_send_req falls only after buf_send_ack=1.
